mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
//  Multi-cycle MIPS main control FSM, directly upstream of the ALU control decoder: sequences
//  each instruction through fetch/decode/execute/memory/writeback and drives ALUOp[1:0] plus the
//  andi/ori/addi/slti one-hot flags that the decoder consumes. Also drives the datapath strobes.
//  Memory accesses use a mem_ready handshake with a timeout.
// PARAMETERS
//  MEM_TIMEOUT  255  max consecutive cycles waiting on mem_ready before abort; 0 = no timeout
// PORTS
//  clk          in   1  single clock, all state on rising edge
//  reset        in   1  synchronous, active-high
//  opcode       in   6  IR[31:26]; sampled only in DECODE
//  mem_ready    in   1  memory completes current read/write this cycle
//  PCWrite      out  1  unconditional PC load
//  PCWriteCond  out  1  PC load if ALU zero (beq)
//  IorD         out  1  0=PC addresses memory, 1=ALUOut
//  MemRead      out  1  memory read request
//  MemWrite     out  1  memory write request
//  IRWrite      out  1  load IR from memory data
//  MemtoReg     out  1  1=MDR to register file
//  RegDst       out  1  1=rd, 0=rt
//  RegWrite     out  1  register file write enable
//  ALUSrcA      out  1  0=PC, 1=rs
//  ALUSrcB      out  2  00=rt 01=const 4 10=sign-ext imm 11=sign-ext imm<<2
//  PCSource     out  2  00=ALU result 01=ALUOut 10=jump target
//  ALUOp        out  2  00 add, 01 sub, 10 R-type funct, 11 immediate
//  andi,ori,addi,slti out 1 each  one-hot immediate flags, valid only in I_EX/I_WB, else 0
//  instr_done   out  1  pulse: last cycle of an instruction (next state FETCH, no abort)
//  illegal_op   out  1  pulse in DECODE for unsupported opcode
//  mem_error    out  1  pulse on the cycle a timeout abort occurs
// BEHAVIOUR
//  - State register resets to FETCH; while reset=1 every output above is forced 0. op_q, wait
//    counter cleared. Reset mid-instruction abandons it; first post-reset cycle is FETCH.
//  - Outputs are Moore (decoded from state/op_q) except IRWrite/PCWrite in FETCH (gated by mem_ready).
//    Any output not listed for a state is 0 (2-bit fields 00).
//  - FETCH: MemRead=1 IorD=0 ALUSrcA=0 ALUSrcB=01 ALUOp=00 PCSource=00; IRWrite=PCWrite=mem_ready;
//    stay until mem_ready -> DECODE.
//  - DECODE: ALUSrcA=0 ALUSrcB=11 ALUOp=00; op_q<=opcode. Next: 000000 R_EX; 100011/101011 MEM_ADDR;
//    000100 BRANCH; 000010 JUMP; 001000/001100/001101/001010 I_EX; other: illegal_op=1, -> FETCH.
//  - MEM_ADDR: ALUSrcA=1 ALUSrcB=10 ALUOp=00 -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: MemRead=1 IorD=1; wait mem_ready -> LOAD_WB. LOAD_WB: RegWrite=1 MemtoReg=1 RegDst=0 -> FETCH.
//  - MEM_WR: MemWrite=1 IorD=1; wait mem_ready -> FETCH.
//  - R_EX: ALUSrcA=1 ALUSrcB=00 ALUOp=10 -> R_WB. R_WB: RegWrite=1 RegDst=1 ALUOp=10 -> FETCH.
//  - BRANCH: ALUSrcA=1 ALUSrcB=00 ALUOp=01 PCWriteCond=1 PCSource=01 -> FETCH.
//  - JUMP: PCWrite=1 PCSource=10 -> FETCH.
//  - I_EX: ALUSrcA=1 ALUSrcB=10 ALUOp=11, flag per op_q (001000 addi, 001100 andi, 001101 ori,
//    001010 slti) -> I_WB. I_WB: same ALU controls and flag held, RegWrite=1 RegDst=0 -> FETCH.
//  - Cycle counts (mem_ready immediate): R/imm 4, lw 5, sw 4, beq 3, j 3.
//  - Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0; clears on any
//    state change or mem_ready=1. When it equals MEM_TIMEOUT (nonzero) with mem_ready still 0:
//    mem_error=1 that cycle, strobes still as per state, next state FETCH, counter cleared,
//    no instr_done. Width = clog2(MEM_TIMEOUT+1), min 1; must not wrap.
//  - mem_ready outside wait states is ignored. instr_done=1 in LOAD_WB, R_WB, I_WB, BRANCH, JUMP,
//    and MEM_WR when mem_ready=1.
//  - Never two of andi/ori/addi/slti high; never MemRead and MemWrite high together.
// TESTING
//  - add (op 000000), mem_ready tied 1 -> FETCH,DECODE,R_EX,R_WB; ALUOp 00,00,10,10; RegWrite+RegDst
//    in cycle 4; instr_done in cycle 4 only.
//  - ori (001101) -> I_EX/I_WB ALUOp=11, ori=1 both cycles, andi/addi/slti=0; flags 0 in all other states.
//  - lw with mem_ready low 3 cycles in MEM_RD -> MemRead/IorD held 4 cycles, then LOAD_WB MemtoReg=1 RegWrite=1.
//  - MEM_TIMEOUT=4, sw with mem_ready stuck 0 -> mem_error pulse on 5th MEM_WR cycle, next FETCH, no instr_done.
//  - opcode 111111 -> illegal_op 1 cycle in DECODE, no RegWrite/MemWrite/PCWrite, back to FETCH.
//  - reset asserted during MEM_RD -> all outputs 0 while high; next cycle FETCH with MemRead=1.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath strobes, ALUOp and the immediate one-hot flags for the ALU control decoder.
module mips_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       andi,
    output logic       ori,
    output logic       addi,
    output logic       slti,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_error
);

    localparam int unsigned CNT_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(MEM_TIMEOUT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_LOAD_WB, S_MEM_WR,
        S_R_EX, S_R_WB, S_BRANCH, S_JUMP, S_I_EX, S_I_WB
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             in_wait;
    logic             timeout;

    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign timeout = (MEM_TIMEOUT != 0) && in_wait && !mem_ready && (wait_cnt == CNT_TMO);

    // Next-state selection; a timeout abandons the instruction and restarts at FETCH
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (timeout)        state_nxt = S_FETCH;
                else if (mem_ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                              state_nxt = S_R_EX;
                    OP_LW, OP_SW:                          state_nxt = S_MEM_ADDR;
                    OP_BEQ:                                state_nxt = S_BRANCH;
                    OP_J:                                  state_nxt = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:     state_nxt = S_I_EX;
                    default:                               state_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (timeout)        state_nxt = S_FETCH;
                else if (mem_ready) state_nxt = S_LOAD_WB;
            end
            S_MEM_WR: begin
                if (timeout || mem_ready) state_nxt = S_FETCH;
            end
            S_R_EX:    state_nxt = S_R_WB;
            S_I_EX:    state_nxt = S_I_WB;
            S_LOAD_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            default:   state_nxt = S_FETCH;
        endcase
    end

    // State, latched opcode and saturating memory wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            op_q     <= 6'd0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) op_q <= opcode;
            if (!in_wait || mem_ready || timeout || (state_nxt != state))
                wait_cnt <= '0;
            else if (wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Moore decode of control strobes; FETCH load strobes follow mem_ready, reset forces all low
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        andi        = 1'b0;
        ori         = 1'b0;
        addi        = 1'b0;
        slti        = 1'b0;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_error   = 1'b0;
        if (!reset) begin
            mem_error = timeout;
            case (state)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = 2'b11;
                    case (opcode)
                        OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal_op = 1'b0;
                        default:                           illegal_op = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_LOAD_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_R_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                S_R_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    ALUOp      = 2'b10;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    instr_done  = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = 2'b10;
                    instr_done = 1'b1;
                end
                S_I_EX, S_I_WB: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    ALUOp   = 2'b11;
                    addi    = (op_q == OP_ADDI);
                    andi    = (op_q == OP_ANDI);
                    ori     = (op_q == OP_ORI);
                    slti    = (op_q == OP_SLTI);
                    if (state == S_I_WB) begin
                        RegWrite   = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-instruction expected cycle sequences are generated
// from instruction-level rules, queued as expectations, and compared by a separate monitor.
module tb_mips_multicycle_control;

    localparam int unsigned TMO = 4;

    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       memtoreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, pcsource, aluop;
        logic       andi, ori, addi, slti, instr_done, illegal_op, mem_error;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [5:0] op;
        outs_t      exp;
    } cyc_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic       andi, ori, addi, slti, instr_done, illegal_op, mem_error;
    outs_t      act;

    cyc_t  iq[$];
    outs_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc_no = 0;

    mips_multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .andi(andi), .ori(ori), .addi(addi), .slti(slti),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, andi, ori, addi, slti,
                  instr_done, illegal_op, mem_error};

    // Monitor: every cycle the DUT presents its strobes; compare against the oldest expectation
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            outs_t e;
            e = sb.pop_front();
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL cycle%0d strobes got=%06h want=%06h", cyc_no, act, e);
            end
        end
    end

    // 0 R, 1 lw, 2 sw, 3 beq, 4 j, 5 addi, 6 andi, 7 ori, 8 slti, -1 unsupported
    function automatic int op_class(input logic [5:0] op);
        case (op)
            6'b000000: return 0;
            6'b100011: return 1;
            6'b101011: return 2;
            6'b000100: return 3;
            6'b000010: return 4;
            6'b001000: return 5;
            6'b001100: return 6;
            6'b001101: return 7;
            6'b001010: return 8;
            default:   return -1;
        endcase
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic logic rmr();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic mr, input logic [5:0] op, input outs_t e);
        cyc_t c;
        c.rst = 1'b0;
        c.mr  = mr;
        c.op  = op;
        c.exp = e;
        iq.push_back(c);
    endtask

    // Memory-wait phase: d not-ready cycles then ready, unless the timeout hits first
    // kind: 0 instruction fetch, 1 load read, 2 store write
    task automatic wait_phase(input int kind, input int d, output bit aborted);
        outs_t b;
        outs_t e;
        int    k;
        bit    fin;
        b = '0;
        if (kind == 0) begin b.memread = 1'b1; b.alusrcb = 2'b01; end
        if (kind == 1) begin b.memread = 1'b1; b.iord = 1'b1; end
        if (kind == 2) begin b.memwrite = 1'b1; b.iord = 1'b1; end
        aborted = 1'b0;
        fin = 1'b0;
        k = 0;
        while (!fin) begin
            e = b;
            if (k == d) begin
                if (kind == 0) begin e.irwrite = 1'b1; e.pcwrite = 1'b1; end
                if (kind == 2) e.instr_done = 1'b1;
                push(1'b1, rop(), e);
                fin = 1'b1;
            end else if (k == int'(TMO)) begin
                e.mem_error = 1'b1;
                push(1'b0, rop(), e);
                aborted = 1'b1;
                fin = 1'b1;
            end else begin
                push(1'b0, rop(), e);
            end
            k++;
        end
    endtask

    function automatic int rdelay();
        if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 2));
        return int'($urandom_range(3, 6));
    endfunction

    // Expected cycle sequence for one instruction (fetch retried after a fetch timeout)
    task automatic build(input logic [5:0] op, input int fd, input int md);
        outs_t e;
        bit    ab;
        int    cl;
        iq.delete();
        cl = op_class(op);
        wait_phase(0, fd, ab);
        while (ab) wait_phase(0, rdelay(), ab);
        e = '0;
        e.alusrcb = 2'b11;
        e.illegal_op = (cl < 0);
        push(rmr(), op, e);
        case (cl)
            0: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
                push(rmr(), rop(), e);
                e = '0; e.regwrite = 1'b1; e.regdst = 1'b1; e.aluop = 2'b10; e.instr_done = 1'b1;
                push(rmr(), rop(), e);
            end
            1, 2: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
                push(rmr(), rop(), e);
                wait_phase(cl, md, ab);
                if (cl == 1 && !ab) begin
                    e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1; e.instr_done = 1'b1;
                    push(rmr(), rop(), e);
                end
            end
            3: begin
                e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcwritecond = 1'b1;
                e.pcsource = 2'b01; e.instr_done = 1'b1;
                push(rmr(), rop(), e);
            end
            4: begin
                e = '0; e.pcwrite = 1'b1; e.pcsource = 2'b10; e.instr_done = 1'b1;
                push(rmr(), rop(), e);
            end
            5, 6, 7, 8: begin
                e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluop = 2'b11;
                e.addi = (cl == 5); e.andi = (cl == 6); e.ori = (cl == 7); e.slti = (cl == 8);
                push(rmr(), rop(), e);
                e.regwrite = 1'b1; e.instr_done = 1'b1;
                push(rmr(), rop(), e);
            end
            default: ;
        endcase
    endtask

    // Cut the sequence after keep cycles (if shorter than it) and hold reset for nrst cycles
    task automatic add_reset(input int keep, input int nrst);
        cyc_t c;
        while (iq.size() > keep) void'(iq.pop_back());
        for (int i = 0; i < nrst; i++) begin
            c.rst = 1'b1;
            c.mr  = rmr();
            c.op  = rop();
            c.exp = '0;
            iq.push_back(c);
        end
    endtask

    // Drive the built sequence one cycle at a time and queue expectations
    task automatic run();
        cyc_t c;
        while (iq.size() > 0) begin
            c = iq.pop_front();
            @(posedge clk);
            #1;
            cyc_no++;
            reset     = c.rst;
            mem_ready = c.mr;
            opcode    = c.op;
            sb.push_back(c.exp);
        end
    endtask

    initial begin
        logic [5:0] legal [9];
        logic [5:0] op;
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                  6'b001000, 6'b001100, 6'b001101, 6'b001010};

        iq.delete();
        add_reset(0, 2);
        run();

        build(6'b000000, 0, 0); run();
        build(6'b001101, 0, 0); run();
        build(6'b100011, 0, 3); run();
        build(6'b101011, 0, 6); run();
        build(6'b111111, 0, 0); run();
        build(6'b100011, 0, 6); add_reset(5, 2); run();
        build(6'b000000, 0, 0); run();
        build(6'b000100, 1, 0); run();
        build(6'b000010, 5, 0); run();

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) op = rop();
            else op = legal[$urandom_range(0, 8)];
            build(op, rdelay(), rdelay());
            if ($urandom_range(0, 29) == 0)
                add_reset(int'($urandom_range(1, 8)), int'($urandom_range(1, 2)));
            run();
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
